// File: rtl/fpga_efuse_loader_pkg.sv
// Shared types and constants for the eFuse configuration loader.
// The CRC helper is only used when FPGA_EFUSE_LOADER_CRC8_EN is defined.
package fpga_efuse_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_SHIFT = 3'd2,
    ST_CHECK = 3'd3,
    ST_DONE  = 3'd4,
    ST_ERR   = 3'd5
  } state_e;

  localparam logic [7:0] CRC8_POLY = 8'h07;
  localparam logic [7:0] CRC8_INIT = 8'h00;

  // One MSB-first step of CRC-8: feed back the top bit XOR the incoming bit.
  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic din);
    logic fb;
    fb = crc[7] ^ din;
    return {crc[6:0], 1'b0} ^ (fb ? CRC8_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/fpga_efuse_crc8.sv
// Bit-serial CRC-8 over the configuration stream (built only with FPGA_EFUSE_LOADER_CRC8_EN).
// Accumulates one bit per enabled cycle; cleared when a load is accepted.
`ifdef FPGA_EFUSE_LOADER_CRC8_EN
module fpga_efuse_crc8
  import fpga_efuse_loader_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       en,
  input  logic       din,
  output logic [7:0] crc
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc <= CRC8_INIT;
    end else if (clr) begin
      crc <= CRC8_INIT;
    end else if (en) begin
      crc <= crc8_step(crc, din);
    end
  end

endmodule
`endif

// File: rtl/fpga_efuse_cfg_loader.sv
// Boot-time eFuse reader: fetches bytes over Wishbone and shifts them MSB-first into the config chain.
// Optional CRC-8 trailer byte check is enabled by defining FPGA_EFUSE_LOADER_CRC8_EN.
module fpga_efuse_cfg_loader
  import fpga_efuse_loader_pkg::*;
#(
  parameter int          BYTE_COUNT  = 64,
  parameter logic [9:0]  BASE_ADDR   = 10'd0,
  parameter int          ACK_TIMEOUT = 255
) (
  input  logic       clk_i,
  input  logic       rstn_i,
  input  logic       start_i,
  output logic       wb_cyc_o,
  output logic       wb_stb_o,
  output logic       wb_we_o,
  output logic       wb_sel_o,
  output logic [9:0] wb_adr_o,
  input  logic [7:0] wb_dat_i,
  input  logic       wb_ack_i,
  output logic       cfg_data_o,
  output logic       cfg_shift_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       err_o
);

  localparam int IDX_W = $clog2(BYTE_COUNT + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTE_COUNT - 1);
  localparam logic [7:0]       TO_LAST  = 8'(ACK_TIMEOUT - 1);

  state_e           state;
  logic [IDX_W-1:0] idx;
  logic [7:0]       tcnt;
  logic [2:0]       bitcnt;
  logic [7:0]       shreg;

  assign wb_we_o  = 1'b0;
  assign wb_sel_o = wb_stb_o;

`ifdef FPGA_EFUSE_LOADER_CRC8_EN
  localparam logic [IDX_W-1:0] CRC_IDX = IDX_W'(BYTE_COUNT);

  logic       start_ok;
  logic [7:0] crc_val;

  assign start_ok = start_i && (state == ST_IDLE || state == ST_DONE || state == ST_ERR);

  fpga_efuse_crc8 u_crc (
    .clk   (clk_i),
    .rst_n (rstn_i),
    .clr   (start_ok),
    .en    (cfg_shift_o),
    .din   (cfg_data_o),
    .crc   (crc_val)
  );
`endif

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state       <= ST_IDLE;
      idx         <= '0;
      tcnt        <= '0;
      bitcnt      <= '0;
      shreg       <= '0;
      wb_cyc_o    <= 1'b0;
      wb_stb_o    <= 1'b0;
      wb_adr_o    <= '0;
      cfg_data_o  <= 1'b0;
      cfg_shift_o <= 1'b0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      err_o       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (start_i) begin
            state    <= ST_REQ;
            idx      <= '0;
            tcnt     <= '0;
            wb_adr_o <= BASE_ADDR;
            wb_cyc_o <= 1'b1;
            wb_stb_o <= 1'b1;
            busy_o   <= 1'b1;
            done_o   <= 1'b0;
            err_o    <= 1'b0;
          end
        end

        // An ack on the final allowed cycle wins over the timeout.
        ST_REQ: begin
          if (wb_ack_i) begin
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            tcnt     <= '0;
            shreg    <= wb_dat_i;
`ifdef FPGA_EFUSE_LOADER_CRC8_EN
            if (idx == CRC_IDX) begin
              state <= ST_CHECK;
            end else
`endif
            begin
              state       <= ST_SHIFT;
              cfg_shift_o <= 1'b1;
              cfg_data_o  <= wb_dat_i[7];
              bitcnt      <= '0;
            end
          end else if (tcnt == TO_LAST) begin
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            state    <= ST_ERR;
            busy_o   <= 1'b0;
            err_o    <= 1'b1;
          end else begin
            tcnt <= tcnt + 8'd1;
          end
        end

        // Bit 7 went out on entry; shreg[6] is always the next bit to present.
        ST_SHIFT: begin
          if (bitcnt == 3'd7) begin
            cfg_shift_o <= 1'b0;
`ifdef FPGA_EFUSE_LOADER_CRC8_EN
            idx      <= idx + 1'b1;
            wb_adr_o <= wb_adr_o + 10'd1;
            wb_cyc_o <= 1'b1;
            wb_stb_o <= 1'b1;
            state    <= ST_REQ;
`else
            if (idx == LAST_IDX) begin
              state  <= ST_DONE;
              busy_o <= 1'b0;
              done_o <= 1'b1;
            end else begin
              idx      <= idx + 1'b1;
              wb_adr_o <= wb_adr_o + 10'd1;
              wb_cyc_o <= 1'b1;
              wb_stb_o <= 1'b1;
              state    <= ST_REQ;
            end
`endif
          end else begin
            cfg_data_o <= shreg[6];
            shreg      <= shreg << 1;
            bitcnt     <= bitcnt + 3'd1;
          end
        end

`ifdef FPGA_EFUSE_LOADER_CRC8_EN
        ST_CHECK: begin
          busy_o <= 1'b0;
          if (crc_val == shreg) begin
            state  <= ST_DONE;
            done_o <= 1'b1;
          end else begin
            state <= ST_ERR;
            err_o <= 1'b1;
          end
        end
`endif

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fpga_efuse_cfg_loader.sv
// Self-checking bench for fpga_efuse_cfg_loader: randomized eFuse contents and ack latency
// against a byte-level reference (expected bit stream, address list, status flags).
module tb_fpga_efuse_cfg_loader;

  localparam int         BC   = 2;
  localparam logic [9:0] BASE = 10'h010;
  localparam int         TO   = 6;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       start = 1'b0;
  logic       cyc, stb, we, sel;
  logic [9:0] adr;
  logic [7:0] dat;
  logic       ack;
  logic       cfg_data, cfg_shift, busy, done, err;

  logic [7:0] mem [0:1023];
  int  n_chk = 0;
  int  n_pass = 0;
  int  fixed_delay = -1;
  bit  no_ack = 1'b0;
  logic [9:0] adr_q[$];
  logic       bit_q[$];
  int  cyc_cycles = 0;
  int  adr_viol = 0;

  always #5 clk = ~clk;

  fpga_efuse_cfg_loader #(
    .BYTE_COUNT  (BC),
    .BASE_ADDR   (BASE),
    .ACK_TIMEOUT (TO)
  ) dut (
    .clk_i       (clk),
    .rstn_i      (rstn),
    .start_i     (start),
    .wb_cyc_o    (cyc),
    .wb_stb_o    (stb),
    .wb_we_o     (we),
    .wb_sel_o    (sel),
    .wb_adr_o    (adr),
    .wb_dat_i    (dat),
    .wb_ack_i    (ack),
    .cfg_data_o  (cfg_data),
    .cfg_shift_o (cfg_shift),
    .busy_o      (busy),
    .done_o      (done),
    .err_o       (err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
  endtask

  // Reference CRC-8 (poly 0x07, init 0), byte-at-a-time.
  function automatic logic [7:0] crc_ref();
    logic [7:0] c;
    c = 8'h00;
    for (int i = 0; i < BC; i++) begin
      c = c ^ mem[BASE + i];
      for (int b = 0; b < 8; b++) c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    end
    return c;
  endfunction

  // Wishbone slave: ack after a chosen number of strobed cycles.
  initial begin : slave
    int cnt, dly;
    ack = 1'b0; dat = 8'h00; cnt = 0; dly = 0;
    forever begin
      @(negedge clk);
      ack = 1'b0;
      if (cyc && stb) begin
        if (cnt == 0) dly = (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(0, TO - 1));
        if (!no_ack && cnt == dly) begin
          ack = 1'b1;
          dat = mem[adr];
          cnt = 0;
        end else begin
          cnt++;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // Observe the shift chain and the bus addresses.
  initial begin : monitor
    logic pcyc;
    logic [9:0] padr;
    pcyc = 1'b0; padr = '0;
    forever begin
      @(negedge clk);
      if (cfg_shift) bit_q.push_back(cfg_data);
      if (cyc) begin
        cyc_cycles++;
        if (!pcyc) adr_q.push_back(adr);
        else if (adr != padr) adr_viol++;
      end
      pcyc = cyc;
      padr = adr;
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1);
  end

  // mode 0: plain load; 1: pulse start during first shift; 2: reset during REQ of byte 1
  task automatic run_load(input int mode);
    bit finished, poked;
    bit_q.delete(); adr_q.delete(); cyc_cycles = 0; adr_viol = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    check("busy_after_start", {busy, done, err}, 3'b100);
    finished = 1'b0; poked = 1'b0;
    for (int k = 0; k < 400 && !finished; k++) begin
      @(negedge clk); start = 1'b0;
      if (!busy) begin
        finished = 1'b1;
      end else if (mode == 1 && !poked && cfg_shift) begin
        start = 1'b1; poked = 1'b1;
      end else if (mode == 2 && cyc && adr == BASE + 10'd1) begin
        rstn = 1'b0;
        #1;
        check("reset_async_outputs",
              {cyc, stb, we, sel, adr, cfg_data, cfg_shift, busy, done, err}, 32'd0);
        finished = 1'b1;
      end
    end
    if (!finished) check("load_completes_in_bound", 0, 1);
  endtask

  task automatic verify_ok(input string name);
    logic [7:0] b;
    int nreads;
`ifdef FPGA_EFUSE_LOADER_CRC8_EN
    nreads = BC + 1;
`else
    nreads = BC;
`endif
    check({name, "_status"}, {busy, done, err, cyc, stb, cfg_shift}, 6'b010000);
    check({name, "_nbits"}, bit_q.size(), BC * 8);
    for (int i = 0; i < BC; i++) begin
      b = 8'h00;
      for (int j = 0; j < 8; j++)
        if (8 * i + j < bit_q.size()) b = {b[6:0], bit_q[8 * i + j]};
      check($sformatf("%s_byte%0d", name, i), b, mem[BASE + i]);
    end
    check({name, "_nreads"}, adr_q.size(), nreads);
    for (int i = 0; i < nreads && i < adr_q.size(); i++)
      check($sformatf("%s_adr%0d", name, i), adr_q[i], BASE + i);
    check({name, "_adr_stable"}, adr_viol, 0);
  endtask

  initial begin : main
    repeat (3) @(negedge clk);
    check("reset_outputs", {cyc, stb, we, sel, adr, cfg_data, cfg_shift, busy, done, err}, 32'd0);
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_after_reset", {cyc, busy, done, err, cfg_shift}, 5'd0);

    mem[BASE] = 8'hA5; mem[BASE + 1] = 8'h3C; mem[BASE + BC] = crc_ref();
    fixed_delay = 0;
    run_load(0); verify_ok("basic");

    fixed_delay = 5;
    run_load(0); verify_ok("delay5");

    fixed_delay = -1;
    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < BC; i++) mem[BASE + i] = 8'($urandom);
      mem[BASE + BC] = crc_ref();
      run_load(0); verify_ok($sformatf("rand%0d", t));
    end

    no_ack = 1'b1;
    run_load(0);
    check("timeout_status", {busy, done, err, cyc, stb}, 5'b00100);
    check("timeout_req_cycles", cyc_cycles, TO);
    check("timeout_no_shift", bit_q.size(), 0);
    check("timeout_nreads", adr_q.size(), 1);
    no_ack = 1'b0;

    for (int i = 0; i < BC; i++) mem[BASE + i] = 8'($urandom);
    mem[BASE + BC] = crc_ref();
    run_load(0); verify_ok("retry");

    fixed_delay = TO - 1;
    run_load(0); verify_ok("ack_at_limit");
    fixed_delay = -1;

    run_load(1); verify_ok("start_while_busy");

    run_load(2);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_after_midload_reset", {cyc, stb, busy, done, err, cfg_shift}, 6'd0);
    run_load(0); verify_ok("after_reset");

`ifdef FPGA_EFUSE_LOADER_CRC8_EN
    mem[BASE] = 8'h01; mem[BASE + 1] = 8'h02; mem[BASE + BC] = 8'h1B;
    check("crc_ref_value", crc_ref(), 8'h1B);
    run_load(0); verify_ok("crc_good");
    mem[BASE + BC] = 8'h00;
    run_load(0);
    check("crc_bad_status", {busy, done, err}, 3'b001);
    check("crc_bad_nbits", bit_q.size(), BC * 8);
    check("crc_bad_nreads", adr_q.size(), BC + 1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
